mem_arb: RTL and testbench
==========================

# mem_arb

Two-port arbiter sharing the single data port of the 256x8 code/data SRAM between the MIPS core (port 0) and a debug/DMA loader (port 1). Accepts at most one access per cycle, drives the SRAM address, write data and write enable from registers, and returns read data with a fixed latency. Supports locked sequences, such as read-modify-write, with a bounded lock timeout. Sits between `mips` and `sram` on the `rw_addr`/`r`/`w`/`w_en` path.

## Interface
- `AW`, 8: address width
- `DW`, 8: data width
- `LOCK_MAX`, 16: maximum cycles a port may hold the lock

- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `p0_req`, `p1_req` in 1: access request, held until granted
- `p0_we`, `p1_we` in 1: 1 = write, 0 = read
- `p0_lock`, `p1_lock` in 1: keep ownership after this access
- `p0_addr`, `p1_addr` in AW: access address
- `p0_wdata`, `p1_wdata` in DW: write data
- `p0_gnt`, `p1_gnt` out 1: request accepted this cycle (combinational)
- `p0_rvalid`, `p1_rvalid` out 1: read data valid (one-cycle pulse)
- `rdata` out DW: read data, shared by both ports, qualified by `pX_rvalid`
- `m_addr` out AW: to SRAM `rw_addr`
- `m_wdata` out DW: to SRAM `w`
- `m_wen` out 1: to SRAM `w_en`
- `m_rdata` in DW: from SRAM `r` (combinational read of `m_addr`)
- `lock_err` out 1: one-cycle pulse on lock timeout

## Operation
- Requester holds `req`, `we`, `lock`, `addr` and `wdata` stable until it samples `gnt`=1 at a rising edge. It may present a new request in the next cycle.
- At most one `gnt` is high per cycle. `gnt` is never high without the matching `req`.
- Lock state:
  - `owner` takes one of {NONE, P0, P1}.
  - A granted access with `lock`=1 sets `owner` to that port.
  - A granted access by the owner with `lock`=0 resets `owner` to NONE.
  - While `owner`≠NONE, only the owner can be granted.
- Lock timeout:
  - `lock_cnt` resets to 0 on every owner grant and increments each cycle while `owner`≠NONE.
  - When `lock_cnt` reaches `LOCK_MAX`, `owner` returns to NONE, `lock_cnt` clears, and `lock_err` pulses for 1 cycle.
  - A grant occurring in the timeout cycle is still honoured.
- Arbitration with `owner`=NONE and both requesting: policy set by the Configuration macro. A single requester is always granted.
- Reset values: `m_addr`=0, `m_wdata`=0, `m_wen`=0, `rdata`=0, `p0_rvalid`=`p1_rvalid`=0, `lock_err`=0, `owner`=NONE, `lock_cnt`=0, round-robin pointer `last`=1 (port 0 is favoured first).
- Reset asserted mid-operation clears every register immediately. An in-flight write (`m_wen`=1) is dropped, and pending `rvalid` pulses are lost.

## Timing
- Grant in cycle N (edge E_N ends cycle N): `m_addr`/`m_wdata`/`m_wen` present the access during cycle N+1.
- Write: SRAM stores at edge E_{N+1}. `m_wen` is 1 for exactly one cycle per granted write.
- Read: `m_rdata` is captured at E_{N+1`. `rdata` and `pX_rvalid` are valid during cycle N+2. Read latency is 2 cycles from grant.
- Throughput: one access per cycle. Back-to-back grants pipeline with no bubble.
- Ordering: a read granted the cycle after a write to the same address returns the new data.
- Cycles with no grant drive `m_wen`=0. `m_addr`/`m_wdata` hold their last values.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On conflict the port other than `last` wins, and `last` updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins conflicts. `last` is not implemented. The lock mechanism is unchanged.

## Test plan
- Reset, then `p0` write addr 8'h10 data 8'h5A, then `p0` read 8'h10 -> `m_wen`=1 for one cycle, `p0_rvalid`=1 with `rdata`=8'h5A two cycles after the read grant.
- Both ports request reads of 8'h01 and 8'h02 continuously for 4 grants -> with `MEM_ARB_RR_EN`: grants P0, P1, P0, P1. Without it: P0 ×4, `p1_gnt`=0.
- `p1` locked write 8'h20 = 8'h07 with `p0` requesting -> `p0_gnt` stays 0 until `p1` unlocked read of 8'h20 is granted. `rdata`=8'h07, then `p0` granted the next cycle.
- `p0` takes lock, then drops `req` -> `lock_err` pulses exactly `LOCK_MAX`=16 cycles later, and `p1` is granted in that cycle or the following one.
- Assert `rst` while `m_wen`=1 for a write of 8'h33 to 8'hFF -> `m_wen` falls immediately, and a later read of 8'hFF returns the old value.
- Back-to-back `p0` writes 8'h00..8'h03 then reads -> one grant per cycle, and read data 8'h00..8'h03 returns in order on consecutive cycles.

Source files
------------

// File: rtl/mem_arb_if.sv
// mem_arb_if: bundle for the mem_arb shared SRAM port.
// Requester side: p0_*/p1_* request fields in, gnt/rvalid out, shared rdata.
// Memory side: m_addr/m_wdata/m_wen to the SRAM, m_rdata back from it.
// lock_err pulses when a held lock times out.
// master = requesters + SRAM environment, slave = the arbiter.
interface mem_arb_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
);
   logic          p0_req;
   logic          p0_we;
   logic          p0_lock;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata;
   logic          p0_gnt;
   logic          p0_rvalid;

   logic          p1_req;
   logic          p1_we;
   logic          p1_lock;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata;
   logic          p1_gnt;
   logic          p1_rvalid;

   logic [DW-1:0] rdata;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_wen;
   logic [DW-1:0] m_rdata;
   logic          lock_err;

   modport master (
      output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
      output m_rdata,
      input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid,
      input  rdata, m_addr, m_wdata, m_wen, lock_err
   );

   modport slave (
      input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
      input  m_rdata,
      output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid,
      output rdata, m_addr, m_wdata, m_wen, lock_err
   );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: two-port arbiter sharing the single SRAM data port between the
// MIPS core (port 0) and the debug/DMA loader (port 1).
// One access per cycle; SRAM address/write data/write enable are registered,
// read data returns two cycles after the grant. A granted access with lock=1
// makes that port the owner; only the owner is granted until it issues an
// unlocked access or LOCK_MAX cycles pass without an owner grant.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - mem_arb_if.slave: p0_*/p1_* request/grant/rvalid, shared rdata,
//          SRAM side m_addr/m_wdata/m_wen/m_rdata, lock_err pulse
// Build macro: MEM_ARB_RR_EN defined -> round-robin on conflicts;
//   undefined -> fixed priority, port 0 wins.
module mem_arb #(
   parameter int unsigned AW       = 8,
   parameter int unsigned DW       = 8,
   parameter int unsigned LOCK_MAX = 16
) (
   input logic      clk,
   input logic      rst,
   mem_arb_if.slave bus
);
   localparam int unsigned CW = $clog2(LOCK_MAX + 1);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_t;

   owner_t        owner_q, owner_nx;
   logic [CW-1:0] cnt_q, cnt_nx;
   logic          lock_err_nx;
   logic          gnt0, gnt1, any_gnt;
   logic          g_we, g_lock;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata;
`ifdef MEM_ARB_RR_EN
   logic          last_q, last_nx;
`endif

   logic [AW-1:0] m_addr_q;
   logic [DW-1:0] m_wdata_q;
   logic          m_wen_q;
   logic          rd0_q, rd1_q;
   logic          rvalid0_q, rvalid1_q;
   logic [DW-1:0] rdata_q;
   logic          lock_err_q;

   // Owner / lock-timeout state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= OWN_NONE;
         cnt_q   <= '0;
`ifdef MEM_ARB_RR_EN
         last_q  <= 1'b1;
`endif
      end else begin
         owner_q <= owner_nx;
         cnt_q   <= cnt_nx;
`ifdef MEM_ARB_RR_EN
         last_q  <= last_nx;
`endif
      end
   end

   // Grant selection and next owner / timeout state
   always_comb begin
      owner_nx    = owner_q;
      cnt_nx      = cnt_q;
      lock_err_nx = 1'b0;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_nx     = last_q;
`endif

      unique case (owner_q)
         OWN_P0: gnt0 = bus.p0_req;
         OWN_P1: gnt1 = bus.p1_req;
         default: begin
            if (bus.p0_req && bus.p1_req) begin
`ifdef MEM_ARB_RR_EN
               // port other than the last winner takes the conflict
               gnt0 = last_q;
               gnt1 = ~last_q;
`else
               gnt0 = 1'b1;
`endif
            end else begin
               gnt0 = bus.p0_req;
               gnt1 = bus.p1_req;
            end
         end
      endcase

      any_gnt = gnt0 | gnt1;
      g_we    = gnt1 ? bus.p1_we    : bus.p0_we;
      g_lock  = gnt1 ? bus.p1_lock  : bus.p0_lock;
      g_addr  = gnt1 ? bus.p1_addr  : bus.p0_addr;
      g_wdata = gnt1 ? bus.p1_wdata : bus.p0_wdata;

      if (any_gnt) begin
         if (g_lock) begin
            owner_nx = gnt1 ? OWN_P1 : OWN_P0;
            cnt_nx   = '0;
         end else if (owner_q != OWN_NONE) begin
            // while owned only the owner is granted, so this is its release
            owner_nx = OWN_NONE;
            cnt_nx   = '0;
         end
`ifdef MEM_ARB_RR_EN
         last_nx = gnt1;
`endif
      end else if (owner_q != OWN_NONE) begin
         // timeout fires on the edge the count would reach LOCK_MAX
         if (cnt_q == CW'(LOCK_MAX - 1)) begin
            owner_nx    = OWN_NONE;
            cnt_nx      = '0;
            lock_err_nx = 1'b1;
         end else begin
            cnt_nx = cnt_q + CW'(1);
         end
      end
   end

   // SRAM command and read-return pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         m_wen_q    <= 1'b0;
         rd0_q      <= 1'b0;
         rd1_q      <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata_q    <= '0;
         lock_err_q <= 1'b0;
      end else begin
         m_wen_q <= any_gnt & g_we;
         if (any_gnt) begin
            m_addr_q  <= g_addr;
            m_wdata_q <= g_wdata;
         end
         rd0_q     <= gnt0 & ~bus.p0_we;
         rd1_q     <= gnt1 & ~bus.p1_we;
         rvalid0_q <= rd0_q;
         rvalid1_q <= rd1_q;
         if (rd0_q | rd1_q) rdata_q <= bus.m_rdata;
         lock_err_q <= lock_err_nx;
      end
   end

   assign bus.p0_gnt    = gnt0;
   assign bus.p1_gnt    = gnt1;
   assign bus.p0_rvalid = rvalid0_q;
   assign bus.p1_rvalid = rvalid1_q;
   assign bus.rdata     = rdata_q;
   assign bus.m_addr    = m_addr_q;
   assign bus.m_wdata   = m_wdata_q;
   assign bus.m_wen     = m_wen_q;
   assign bus.lock_err  = lock_err_q;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios plus randomized traffic for mem_arb, checked
// every cycle against a transaction-level model (owner, lock age, memory
// image, expected return pipeline) and a set of hand-computed expectations.
module tb_mem_arb;
   localparam int unsigned AW       = 8;
   localparam int unsigned DW       = 8;
   localparam int unsigned LOCK_MAX = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arb_if #(.AW(AW), .DW(DW)) bus ();

   mem_arb #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // SRAM behaviour (not reset) and bench bookkeeping
   logic [7:0] sram [256];
   assign bus.m_rdata = sram[bus.m_addr];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // model state
   logic [7:0] mmem [256];
   int         own, since, last;
   bit         eg0, eg1, s_we, s_lock;
   logic [7:0] s_addr, s_wdata;
   bit         pw_v;
   logic [7:0] pw_a, pw_d;
   bit         e_wen, st_rd0, st_rd1, e_rv0, e_rv1, e_lerr;
   logic [7:0] e_addr, e_wdata, st_val, e_rdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sram_loop();
      forever begin
         @(posedge clk);
         cyc++;
         if (bus.m_wen) sram[bus.m_addr] <= bus.m_wdata;
      end
   endtask

   // Reference model: advances one transaction step per clock edge
   task automatic model_loop();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            own = 0; since = 0; last = 1; pw_v = 0;
            e_wen = 0; e_addr = 0; e_wdata = 0;
            st_rd0 = 0; st_rd1 = 0; st_val = 0;
            e_rv0 = 0; e_rv1 = 0; e_rdata = 0; e_lerr = 0;
         end else begin
            if (pw_v) mmem[pw_a] = pw_d;
            e_rv0 = st_rd0;
            e_rv1 = st_rd1;
            if (st_rd0 || st_rd1) e_rdata = st_val;
            st_rd0 = eg0 && !s_we;
            st_rd1 = eg1 && !s_we;
            st_val = mmem[s_addr];
            pw_v   = (eg0 || eg1) && s_we;
            pw_a   = s_addr;
            pw_d   = s_wdata;
            e_wen  = pw_v;
            if (eg0 || eg1) begin
               e_addr  = s_addr;
               e_wdata = s_wdata;
            end
            e_lerr = 0;
            if (eg0 || eg1) begin
               if (s_lock) begin
                  own = eg1 ? 2 : 1; since = 0;
               end else if (own == (eg1 ? 2 : 1)) begin
                  own = 0; since = 0;
               end
               last = eg1 ? 1 : 0;
            end else if (own != 0) begin
               since++;
               if (since == LOCK_MAX) begin
                  own = 0; since = 0; e_lerr = 1;
               end
            end
         end
      end
   endtask

   // Per-cycle comparison at the falling edge
   task automatic compare_loop();
      forever begin
         @(negedge clk);
         eg0 = 0; eg1 = 0;
         if (!rst) begin
            if (own == 1)      eg0 = bus.p0_req;
            else if (own == 2) eg1 = bus.p1_req;
            else if (bus.p0_req && bus.p1_req) begin
`ifdef MEM_ARB_RR_EN
               if (last == 0) eg1 = 1; else eg0 = 1;
`else
               eg0 = 1;
`endif
            end else begin
               eg0 = bus.p0_req;
               eg1 = bus.p1_req;
            end
            s_we    = eg1 ? bus.p1_we    : bus.p0_we;
            s_lock  = eg1 ? bus.p1_lock  : bus.p0_lock;
            s_addr  = eg1 ? bus.p1_addr  : bus.p0_addr;
            s_wdata = eg1 ? bus.p1_wdata : bus.p0_wdata;
            chk("p0_gnt", 32'(bus.p0_gnt), 32'(eg0));
            chk("p1_gnt", 32'(bus.p1_gnt), 32'(eg1));
            chk("m_wen", 32'(bus.m_wen), 32'(e_wen));
            chk("m_addr", 32'(bus.m_addr), 32'(e_addr));
            chk("m_wdata", 32'(bus.m_wdata), 32'(e_wdata));
            chk("p0_rvalid", 32'(bus.p0_rvalid), 32'(e_rv0));
            chk("p1_rvalid", 32'(bus.p1_rvalid), 32'(e_rv1));
            chk("lock_err", 32'(bus.lock_err), 32'(e_lerr));
            if (e_rv0 || e_rv1) chk("rdata", 32'(bus.rdata), 32'(e_rdata));
         end
      end
   endtask

   task automatic set_p0(input logic req, input logic we, input logic lk,
                         input logic [7:0] a, input logic [7:0] d);
      bus.p0_req = req; bus.p0_we = we; bus.p0_lock = lk; bus.p0_addr = a; bus.p0_wdata = d;
   endtask

   task automatic set_p1(input logic req, input logic we, input logic lk,
                         input logic [7:0] a, input logic [7:0] d);
      bus.p1_req = req; bus.p1_we = we; bus.p1_lock = lk; bus.p1_addr = a; bus.p1_wdata = d;
   endtask

   task automatic idle_all();
      set_p0(0, 0, 0, 8'h00, 8'h00);
      set_p1(0, 0, 0, 8'h00, 8'h00);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_all();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Waits for the grant of the presented request; returns just after the grant edge
   task automatic wait_gnt(input int port, output int gc);
      bit got;
      got = 0;
      gc  = -1;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if ((port == 0) ? bus.p0_gnt : bus.p1_gnt) begin
            got = 1;
            gc  = cyc;
         end
         step();
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL wait_gnt: port %0d got no grant, required one within 40 cycles", port);
      end
   endtask

   task automatic new_req(input int port);
      logic       we, lk;
      logic [7:0] a, d;
      we = 1'($urandom_range(0, 1));
      lk = ($urandom_range(0, 4) == 0);
      a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      if (port == 0) set_p0(1, we, lk, a, d);
      else           set_p1(1, we, lk, a, d);
   endtask

   initial begin
      int         g, g2, le, pg, pat, exp_pat;
      bit         a0, a1, gs0, gs1;
      int         q0, q1;

      for (int i = 0; i < 256; i++) begin
         sram[i] = 8'hEE;
         mmem[i] = 8'hEE;
      end
      idle_all();
      fork
         sram_loop();
         model_loop();
         compare_loop();
      join_none

      // reset values
      do_reset();
      chk("rst m_addr", 32'(bus.m_addr), 32'h0);
      chk("rst m_wdata", 32'(bus.m_wdata), 32'h0);
      chk("rst m_wen", 32'(bus.m_wen), 32'h0);
      chk("rst rdata", 32'(bus.rdata), 32'h0);
      chk("rst p0_rvalid", 32'(bus.p0_rvalid), 32'h0);
      chk("rst p1_rvalid", 32'(bus.p1_rvalid), 32'h0);
      chk("rst lock_err", 32'(bus.lock_err), 32'h0);

      // write 10=5A then read it back
      set_p0(1, 1, 0, 8'h10, 8'h5A);
      wait_gnt(0, g);
      set_p0(1, 0, 0, 8'h10, 8'h00);
      chk("t1 m_wen after write grant", 32'(bus.m_wen), 32'h1);
      chk("t1 m_addr after write grant", 32'(bus.m_addr), 32'h10);
      wait_gnt(0, g2);
      set_p0(0, 0, 0, 8'h00, 8'h00);
      chk("t1 read granted next cycle", 32'(g2), 32'(g + 1));
      chk("t1 m_wen one cycle", 32'(bus.m_wen), 32'h0);
      step();
      chk("t1 p0_rvalid", 32'(bus.p0_rvalid), 32'h1);
      chk("t1 rdata", 32'(bus.rdata), 32'h5A);

      // both ports read continuously
      do_reset();
      set_p0(1, 0, 0, 8'h01, 8'h00);
      set_p1(1, 0, 0, 8'h02, 8'h00);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pat = {bus.p1_gnt, bus.p0_gnt};
`ifdef MEM_ARB_RR_EN
         exp_pat = (i % 2 == 0) ? 1 : 2;
`else
         exp_pat = 1;
`endif
         chk($sformatf("t2 grant pattern %0d", i), 32'(pat), 32'(exp_pat));
         step();
      end
      idle_all();
      repeat (3) step();

      // p1 locked write then unlocked read; p0 blocked meanwhile
      do_reset();
      set_p1(1, 1, 1, 8'h20, 8'h07);
      wait_gnt(1, g);
      set_p1(0, 0, 0, 8'h00, 8'h00);
      set_p0(1, 0, 0, 8'h30, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t3 p0 blocked %0d", i), 32'(bus.p0_gnt), 32'h0);
         step();
      end
      set_p1(1, 0, 0, 8'h20, 8'h00);
      wait_gnt(1, g2);
      set_p1(0, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      chk("t3 p0 granted after unlock", 32'(bus.p0_gnt), 32'h1);
      step();
      set_p0(0, 0, 0, 8'h00, 8'h00);
      chk("t3 p1_rvalid", 32'(bus.p1_rvalid), 32'h1);
      chk("t3 rdata", 32'(bus.rdata), 32'h07);
      repeat (3) step();

      // lock timeout
      do_reset();
      set_p0(1, 0, 1, 8'h05, 8'h00);
      wait_gnt(0, g);
      set_p0(0, 0, 0, 8'h00, 8'h00);
      set_p1(1, 0, 0, 8'h06, 8'h00);
      le = -1;
      pg = -1;
      for (int i = 0; i < 40 && (le < 0 || pg < 0); i++) begin
         @(negedge clk);
         if (bus.lock_err && le < 0) le = cyc;
         if (bus.p1_gnt && pg < 0) pg = cyc;
         step();
         if (pg >= 0) set_p1(0, 0, 0, 8'h00, 8'h00);
      end
      chk("t4 lock_err delay from lock grant", 32'(le - g), 32'(LOCK_MAX + 1));
      chk("t4 p1 granted at timeout", 32'((pg >= 0 && le >= 0) && (pg == le || pg == le + 1)), 32'h1);
      idle_all();
      repeat (3) step();

      // reset during an in-flight write
      do_reset();
      set_p0(1, 1, 0, 8'hFF, 8'h11);
      wait_gnt(0, g);
      set_p0(0, 0, 0, 8'h00, 8'h00);
      repeat (2) step();
      set_p0(1, 1, 0, 8'hFF, 8'h33);
      wait_gnt(0, g);
      set_p0(0, 0, 0, 8'h00, 8'h00);
      chk("t5 m_wen before reset", 32'(bus.m_wen), 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("t5 m_wen cleared by reset", 32'(bus.m_wen), 32'h0);
      chk("t5 m_addr cleared by reset", 32'(bus.m_addr), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      set_p0(1, 0, 0, 8'hFF, 8'h00);
      wait_gnt(0, g);
      set_p0(0, 0, 0, 8'h00, 8'h00);
      step();
      chk("t5 p0_rvalid", 32'(bus.p0_rvalid), 32'h1);
      chk("t5 old value kept", 32'(bus.rdata), 32'h11);

      // back-to-back writes then reads
      do_reset();
      for (int j = 0; j < 10; j++) begin
         if (j < 4)      set_p0(1, 1, 0, 8'(8'h50 + j), 8'(j));
         else if (j < 8) set_p0(1, 0, 0, 8'(8'h50 + j - 4), 8'h00);
         else            set_p0(0, 0, 0, 8'h00, 8'h00);
         @(negedge clk);
         if (j < 8) chk($sformatf("t6 gnt %0d", j), 32'(bus.p0_gnt), 32'h1);
         if (j >= 6) begin
            chk($sformatf("t6 rvalid %0d", j), 32'(bus.p0_rvalid), 32'h1);
            chk($sformatf("t6 rdata %0d", j), 32'(bus.rdata), 32'(j - 6));
         end
         step();
      end

      // randomized traffic
      do_reset();
      a0 = 0; a1 = 0; q0 = 0; q1 = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         gs0 = bus.p0_gnt;
         gs1 = bus.p1_gnt;
         step();
         if (gs0) a0 = 0;
         if (gs1) a1 = 0;
         if (!a0) begin
            if (q0 > 0) begin
               q0--;
               bus.p0_req = 0;
            end else if ($urandom_range(0, 3) != 0) begin
               a0 = 1;
               new_req(0);
            end else begin
               bus.p0_req = 0;
               if ($urandom_range(0, 31) == 0) q0 = 20;
            end
         end
         if (!a1) begin
            if (q1 > 0) begin
               q1--;
               bus.p1_req = 0;
            end else if ($urandom_range(0, 3) != 0) begin
               a1 = 1;
               new_req(1);
            end else begin
               bus.p1_req = 0;
               if ($urandom_range(0, 31) == 0) q1 = 20;
            end
         end
      end
      idle_all();
      repeat (5) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
